// File: rtl/fetch_controller.sv
// IF-stage fetch controller: PC sequencing, 2-entry fetch buffer, redirects, sticky faults.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        fault,
  output logic [1:0]  fault_code
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int          CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  // Handshake: an entry transfers on a rising edge where instr_valid && instr_ready;
  // instr_valid never depends on instr_ready, and the head is stable while unaccepted.
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
  logic [31:0]      e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic             pop, push, can_push, oor, redirect_take;

  assign instr_valid  = (count_q != '0);
  assign imem_addr    = pc_q;
  assign instr_out    = e0_ins_q;
  assign pc_out       = e0_pc_q;
  assign pc_plus4_out = e0_pc_q + 32'd4;
  assign fault        = fault_q;
  assign fault_code   = code_q;

  assign pop           = instr_valid && instr_ready;
  assign can_push      = (state_q == S_RUN) && ((count_q != CNT_W'(BUF_DEPTH)) || pop);
  assign oor           = (pc_q >= PC_LIMIT);
  assign redirect_take = redirect_valid && (state_q != S_HALT);
  assign push          = can_push && !redirect_take && !oor;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    e0_pc_d  = e0_pc_q;
    e0_ins_d = e0_ins_q;
    e1_pc_d  = e1_pc_q;
    e1_ins_d = e1_ins_q;
    fault_d  = fault_q;
    code_d   = code_q;
    if (redirect_take) begin
      // Redirect wins over push and pop: the whole buffer is discarded.
      count_d = '0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = S_HALT;
        fault_d = 1'b1;
        code_d  = 2'b01;
      end else begin
        pc_d    = redirect_pc;
        state_d = S_FLUSH;
      end
    end else begin
      if (state_q == S_FLUSH) state_d = S_RUN;
      if (can_push && oor) begin
        state_d = S_HALT;
        fault_d = 1'b1;
        code_d  = 2'b10;
      end
      if (pop && (count_q == CNT_W'(2))) begin
        e0_pc_d  = e1_pc_q;
        e0_ins_d = e1_ins_q;
      end
      if (push) begin
        // Slot for the new entry is the occupancy left after any pop.
        if ((count_q - CNT_W'(pop)) == '0) begin
          e0_pc_d  = pc_q;
          e0_ins_d = imem_rd;
        end else begin
          e1_pc_d  = pc_q;
          e1_ins_d = imem_rd;
        end
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q - CNT_W'(pop) + CNT_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      e0_pc_q  <= '0;
      e0_ins_q <= '0;
      e1_pc_q  <= '0;
      e1_ins_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      e0_pc_q  <= e0_pc_d;
      e0_ins_q <= e0_ins_d;
      e1_pc_q  <= e1_pc_d;
      e1_ins_q <= e1_ins_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (!instr_valid && (state_q != S_HALT)) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: sequential fetch, backpressure, redirects,
// misaligned fault, out-of-range fault (MEM_WORDS=4 instance), reset priority.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic [31:0] imem_addr, imem_rd, instr_out, pc_out, pc_plus4_out;
  logic        instr_valid, fault;
  logic [1:0]  fault_code;
  logic [31:0] s_imem_addr, s_imem_rd, s_instr_out, s_pc_out, s_pc_plus4_out;
  logic        s_instr_valid, s_fault;
  logic [1:0]  s_fault_code;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, s_perf_fetched, s_perf_bubbles;
`endif

  logic [31:0] mem [0:63];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  assign imem_rd   = mem[imem_addr[7:2]];
  assign s_imem_rd = mem[s_imem_addr[7:2]];

  fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(64), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .fault(fault), .fault_code(fault_code)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(4), .BUF_DEPTH(2)) u_small (
    .clk(clk), .reset(reset), .imem_addr(s_imem_addr), .imem_rd(s_imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(s_instr_valid), .instr_ready(instr_ready), .instr_out(s_instr_out),
    .pc_out(s_pc_out), .pc_plus4_out(s_pc_plus4_out), .fault(s_fault), .fault_code(s_fault_code)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(s_perf_fetched), .perf_bubbles(s_perf_bubbles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench just after the release edge, i.e. at the start of cycle 0.
  task automatic do_reset(input logic ready);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = ready;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
    total++; if (instr_out !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
    total++; if (pc_out !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    total++; if (pc_plus4_out !== 32'd4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", pc_plus4_out); end
    total++; if ({fault, fault_code} !== 3'b000) begin bad++; $display("FAIL reset_fault got=%b exp=000", {fault, fault_code}); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_ins [0:3];
    exp_ins[0] = 32'd11; exp_ins[1] = 32'd22; exp_ins[2] = 32'd33; exp_ins[3] = 32'd44;
    do_reset(1'b1);
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_cycle0_valid got=%0b exp=0", instr_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr_out !== exp_ins[k] || pc_out !== 32'(4 * k) ||
          pc_plus4_out !== 32'(4 * k + 4)) begin
        bad++;
        $display("FAIL seq_head%0d got v=%0b ins=%0d pc=%h pc4=%h exp v=1 ins=%0d pc=%h pc4=%h",
                 k, instr_valid, instr_out, pc_out, pc_plus4_out, exp_ins[k], 4 * k, 4 * k + 4);
      end
`ifdef FETCH_PERF_CNT_EN
      if (k == 3) begin
        total++; if (perf_fetched !== 32'd4) begin bad++; $display("FAIL perf_fetched got=%0d exp=4", perf_fetched); end
        total++; if (perf_bubbles !== 32'd1) begin bad++; $display("FAIL perf_bubbles got=%0d exp=1", perf_bubbles); end
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr_out !== 32'd11 || pc_out !== 32'd0 || imem_addr !== 32'd8) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%0b ins=%0d pc=%h addr=%h exp v=1 ins=11 pc=0 addr=8",
                 k, instr_valid, instr_out, pc_out, imem_addr);
      end
    end
    exp_q = {32'd0, 32'd4, 32'd8};
    @(posedge clk); #1 instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (instr_valid !== 1'b1 || pc_out !== e || instr_out !== mem[e[7:2]]) begin
        bad++;
        $display("FAIL bp_drain%0d got v=%0b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                 k, instr_valid, pc_out, instr_out, e, mem[e[7:2]]);
      end
    end
  endtask

  // Fills the buffer (ready low for cycles 0-1), then redirects in cycle 2 with ready high.
  task automatic fill_then_redirect(input logic [31:0] target);
    do_reset(1'b0);
    repeat (2) @(posedge clk);
    #1 instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = target;
  endtask

  task automatic test_redirect;
    fill_then_redirect(32'h20);
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 32'd0) begin bad++; $display("FAIL rd_full got v=%0b pc=%h exp v=1 pc=0", instr_valid, pc_out); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h20) begin bad++; $display("FAIL rd_bubble got v=%0b addr=%h exp v=0 addr=20", instr_valid, imem_addr); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_fetch got v=%0b exp=0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 32'h20 || instr_out !== mem[8]) begin bad++; $display("FAIL rd_first got v=%0b pc=%h ins=%h exp v=1 pc=20 ins=%h", instr_valid, pc_out, instr_out, mem[8]); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 32'h24 || instr_out !== mem[9]) begin bad++; $display("FAIL rd_second got v=%0b pc=%h ins=%h exp v=1 pc=24 ins=%h", instr_valid, pc_out, instr_out, mem[9]); end
  endtask

  task automatic test_back_to_back;
    fill_then_redirect(32'h20);
    @(posedge clk); #1 redirect_pc = 32'h40;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h20) begin bad++; $display("FAIL b2b_first got v=%0b addr=%h exp v=0 addr=20", instr_valid, imem_addr); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin bad++; $display("FAIL b2b_second got v=%0b addr=%h exp v=0 addr=40", instr_valid, imem_addr); end
    repeat (2) @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 32'h40 || instr_out !== mem[16]) begin bad++; $display("FAIL b2b_head got v=%0b pc=%h ins=%h exp v=1 pc=40 ins=%h", instr_valid, pc_out, instr_out, mem[16]); end
  endtask

  task automatic test_misaligned;
    do_reset(1'b1);
    repeat (2) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h22;
    @(posedge clk); #1 redirect_pc = 32'h40;
    @(negedge clk);
    total++; if ({fault, fault_code} !== 3'b101 || instr_valid !== 1'b0 || imem_addr !== 32'd8) begin bad++; $display("FAIL mis_fault got f=%0b code=%b v=%0b addr=%h exp f=1 code=01 v=0 addr=8", fault, fault_code, instr_valid, imem_addr); end
    repeat (3) @(negedge clk);
    total++; if ({fault, fault_code} !== 3'b101 || instr_valid !== 1'b0 || imem_addr !== 32'd8) begin bad++; $display("FAIL mis_ignore got f=%0b code=%b v=%0b addr=%h exp f=1 code=01 v=0 addr=8", fault, fault_code, instr_valid, imem_addr); end
    #1 redirect_valid = 1'b0;
  endtask

  task automatic test_out_of_range;
    do_reset(1'b1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (s_instr_valid !== 1'b1 || s_pc_out !== 32'(4 * k) || s_instr_out !== mem[k] || s_fault !== 1'b0) begin
        bad++;
        $display("FAIL oor_head%0d got v=%0b pc=%h ins=%h f=%0b exp v=1 pc=%h ins=%h f=0",
                 k, s_instr_valid, s_pc_out, s_instr_out, s_fault, 4 * k, mem[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (s_instr_valid !== 1'b0 || {s_fault, s_fault_code} !== 3'b110 || s_imem_addr !== 32'd16) begin
        bad++;
        $display("FAIL oor_halt%0d got v=%0b f=%0b code=%b addr=%h exp v=0 f=1 code=10 addr=10",
                 k, s_instr_valid, s_fault, s_fault_code, s_imem_addr);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h22;
    @(posedge clk);
    #1 reset = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00 || imem_addr !== 32'd0 || pc_out !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got v=%0b f=%0b code=%b addr=%h pc=%h exp v=0 f=0 code=00 addr=0 pc=0",
               instr_valid, fault, fault_code, imem_addr, pc_out);
    end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 32'd0 || instr_out !== 32'd11) begin bad++; $display("FAIL reset_mid_run got v=%0b pc=%h ins=%0d exp v=1 pc=0 ins=11", instr_valid, pc_out, instr_out); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 16);
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    test_reset;
    test_sequential;
    test_backpressure;
    test_redirect;
    test_back_to_back;
    test_misaligned;
    test_out_of_range;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
